// File: rtl/pipe_hazard_sb.sv
// Scoreboard hazard unit: tracks in-flight destinations over NSTG post-decode stages and
// drives D stall, E bubble and D/E forward selects. Optional macro: PIPE_HAZARD_SB_R0_ZERO_EN.
module pipe_hazard_sb #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NSTG = 3,
    parameter int FW   = 2,
    parameter int RW   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          validD_i,
    input  logic [AW-1:0] rsD_i,
    input  logic [AW-1:0] rtD_i,
    input  logic          useRsD_i,
    input  logic          useRtD_i,
    input  logic          BranchD_i,
    input  logic          RFWED_i,
    input  logic [AW-1:0] RFAD_i,
    input  logic [RW-1:0] RdyD_i,
    input  logic          HoldAll_i,
    output logic          Stall_o,
    output logic          FlushE_o,
    output logic [FW-1:0] ForwardAD_o,
    output logic [FW-1:0] ForwardBD_o,
    output logic [FW-1:0] ForwardAE_o,
    output logic [FW-1:0] ForwardBE_o
);

    if (AW != $clog2(NREG) || FW != $clog2(NSTG + 1)) begin : g_param_check
        $error("pipe_hazard_sb: AW/FW inconsistent with NREG/NSTG");
    end

`ifdef PIPE_HAZARD_SB_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    typedef struct packed {
        logic          v;
        logic [AW-1:0] wa;
        logic [RW-1:0] rdy;
    } entry_t;

    typedef struct packed {
        logic          hit;
        logic [FW-1:0] idx;
        logic [RW-1:0] rdy;
    } match_t;

    entry_t [NSTG-1:0] entry_q, entry_d;
    logic [AW-1:0]     rsE_q, rsE_d, rtE_q, rtE_d;
    logic              useRsE_q, useRsE_d, useRtE_q, useRtE_d;

    match_t m_rsD, m_rtD, m_rsE, m_rtE;
    logic   haz_rs, haz_rt, hazard;

    function automatic logic addr_live(input logic [AW-1:0] r);
        return !R0_ZERO || (r != '0);
    endfunction

    // Scan oldest to youngest so the lowest matching index is the one left standing.
    function automatic match_t youngest(input logic [AW-1:0] r, input entry_t [NSTG-1:0] ent);
        match_t m;
        m = '0;
        for (int k = NSTG - 1; k >= 0; k--) begin
            if (ent[k].v && ent[k].wa == r && addr_live(r)) begin
                m.hit = 1'b1;
                m.idx = FW'(k);
                m.rdy = ent[k].rdy;
            end
        end
        return m;
    endfunction

    function automatic logic [FW-1:0] fwd_sel(input match_t m);
        return (m.hit && int'(m.idx) >= int'(m.rdy)) ? FW'(int'(m.idx) + 1) : '0;
    endfunction

    function automatic logic src_hazard(input match_t m, input logic used, input logic branch);
        return used && m.hit &&
               ((int'(m.idx) + 1 < int'(m.rdy)) || (branch && int'(m.idx) < int'(m.rdy)));
    endfunction

    always_comb begin
        m_rsD = youngest(rsD_i, entry_q);
        m_rtD = youngest(rtD_i, entry_q);
        m_rsE = youngest(rsE_q, entry_q);
        m_rtE = youngest(rtE_q, entry_q);

        haz_rs = validD_i && src_hazard(m_rsD, useRsD_i, BranchD_i);
        haz_rt = validD_i && src_hazard(m_rtD, useRtD_i, BranchD_i);
        hazard = haz_rs || haz_rt;

        Stall_o     = HoldAll_i || hazard;
        FlushE_o    = hazard && !HoldAll_i;
        ForwardAD_o = BranchD_i ? fwd_sel(m_rsD) : '0;
        ForwardBD_o = BranchD_i ? fwd_sel(m_rtD) : '0;
        ForwardAE_o = useRsE_q ? fwd_sel(m_rsE) : '0;
        ForwardBE_o = useRtE_q ? fwd_sel(m_rtE) : '0;
    end

    // NOTE: every variable gets a value on every path through always_comb, else a latch is inferred.
    always_comb begin
        entry_d = entry_q;
        for (int k = 1; k < NSTG; k++) begin
            entry_d[k] = entry_q[k-1];
        end
        entry_d[0].v   = validD_i && RFWED_i && !hazard && addr_live(RFAD_i);
        entry_d[0].wa  = RFAD_i;
        entry_d[0].rdy = RdyD_i;

        rsE_d    = hazard ? '0 : rsD_i;
        rtE_d    = hazard ? '0 : rtD_i;
        useRsE_d = !hazard && useRsD_i;
        useRtE_d = !hazard && useRtD_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only the valid bits need clearing; wa/rdy are never looked at while v is low.
            for (int k = 0; k < NSTG; k++) begin
                entry_q[k].v <= 1'b0;
            end
            rsE_q    <= '0;
            rtE_q    <= '0;
            useRsE_q <= 1'b0;
            useRtE_q <= 1'b0;
        end else if (!HoldAll_i) begin
            entry_q  <= entry_d;
            rsE_q    <= rsE_d;
            rtE_q    <= rtE_d;
            useRsE_q <= useRsE_d;
            useRtE_q <= useRtE_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_sb.sv
// Table-driven bench for pipe_hazard_sb (NSTG = 3): each cycle's D inputs carry the expected
// combinational outputs, queued at drive time and popped when sampled.
module tb_pipe_hazard_sb;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NSTG = 3;
    localparam int FW   = 2;
    localparam int RW   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          validD, useRsD, useRtD, BranchD, RFWED, HoldAll;
    logic [AW-1:0] rsD, rtD, RFAD;
    logic [RW-1:0] RdyD;
    logic          Stall, FlushE;
    logic [FW-1:0] ForwardAD, ForwardBD, ForwardAE, ForwardBE;

    always #5 clk = ~clk;

    pipe_hazard_sb #(.NREG(NREG), .AW(AW), .NSTG(NSTG), .FW(FW), .RW(RW)) dut (
        .clk        (clk),
        .rst        (rst),
        .validD_i   (validD),
        .rsD_i      (rsD),
        .rtD_i      (rtD),
        .useRsD_i   (useRsD),
        .useRtD_i   (useRtD),
        .BranchD_i  (BranchD),
        .RFWED_i    (RFWED),
        .RFAD_i     (RFAD),
        .RdyD_i     (RdyD),
        .HoldAll_i  (HoldAll),
        .Stall_o    (Stall),
        .FlushE_o   (FlushE),
        .ForwardAD_o(ForwardAD),
        .ForwardBD_o(ForwardBD),
        .ForwardAE_o(ForwardAE),
        .ForwardBE_o(ForwardBE)
    );

    typedef struct packed {
        logic          rst, hold, valid;
        logic [AW-1:0] rs, rt;
        logic          urs, urt, br, we;
        logic [AW-1:0] rfa;
        logic [RW-1:0] rdy;
    } in_t;

    typedef struct packed {
        logic          stall, flush;
        logic [FW-1:0] fad, fbd, fae, fbe;
    } out_t;

    typedef struct {
        string name;
        in_t   stim;
        out_t  exp;
    } vec_t;

    vec_t  vecs[$];
    out_t  sb_q[$];
    string name_q[$];
    int    n_vec = 0;
    int    n_bad = 0;

    function automatic in_t nop();
        in_t s = '0;
        return s;
    endfunction

    function automatic in_t wr(int a, int r);
        in_t s = '0;
        s.valid = 1'b1; s.we = 1'b1; s.rfa = AW'(a); s.rdy = RW'(r);
        return s;
    endfunction

    function automatic in_t rd(int a, int b);
        in_t s = '0;
        s.valid = 1'b1; s.rs = AW'(a); s.rt = AW'(b); s.urs = 1'b1; s.urt = 1'b1;
        return s;
    endfunction

    function automatic in_t br(int a, int b);
        in_t s = rd(a, b);
        s.br = 1'b1;
        return s;
    endfunction

    function automatic in_t held(in_t s);
        in_t h = s;
        h.hold = 1'b1;
        return h;
    endfunction

    function automatic out_t o(int st, int fl, int ad, int bd, int ae, int be);
        out_t r;
        r.stall = st[0]; r.flush = fl[0];
        r.fad = FW'(ad); r.fbd = FW'(bd); r.fae = FW'(ae); r.fbe = FW'(be);
        return r;
    endfunction

    task automatic add(input string nm, input in_t s, input out_t e);
        vecs.push_back('{nm, s, e});
    endtask

    task automatic drive(input in_t s);
        rst = s.rst; HoldAll = s.hold; validD = s.valid;
        rsD = s.rs; rtD = s.rt; useRsD = s.urs; useRtD = s.urt;
        BranchD = s.br; RFWED = s.we; RFAD = s.rfa; RdyD = s.rdy;
    endtask

    task automatic check();
        out_t  got, want;
        string nm;
        want = sb_q.pop_front();
        nm   = name_q.pop_front();
        got  = '{Stall, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE};
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got stall=%0b flush=%0b fad=%0d fbd=%0d fae=%0d fbe=%0d, want stall=%0b flush=%0b fad=%0d fbd=%0d fae=%0d fbe=%0d",
                     nm, got.stall, got.flush, got.fad, got.fbd, got.fae, got.fbe,
                     want.stall, want.flush, want.fad, want.fbd, want.fae, want.fbe);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later, well clear of the rising edge.
    task automatic step(input string nm, input in_t s, input out_t e);
        @(negedge clk);
        drive(s);
        sb_q.push_back(e);
        name_q.push_back(nm);
        #1;
        check();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finish earlier", $time);
        $fatal(1);
    end

    initial begin
        in_t rst_in;
        rst_in     = nop();
        rst_in.rst = 1'b1;

        add("reset_idle",     nop(),      o(0, 0, 0, 0, 0, 0));
        // ALU result ready out of E: consumer proceeds and takes it from M
        add("alu_w3",         wr(3, 1),   o(0, 0, 0, 0, 0, 0));
        add("rd_r3_nostall",  rd(3, 4),   o(0, 0, 0, 0, 0, 0));
        add("fwd_ae_m",       nop(),      o(0, 0, 0, 0, 2, 0));
        add("idle_1",         nop(),      o(0, 0, 0, 0, 0, 0));
        // load-use: one bubble, then W forward
        add("ld_w5",          wr(5, 2),   o(0, 0, 0, 0, 0, 0));
        add("rd_rt5_stall",   rd(1, 5),   o(1, 1, 0, 0, 0, 0));
        add("rd_rt5_go",      rd(1, 5),   o(0, 0, 0, 0, 0, 0));
        add("fwd_be_w",       nop(),      o(0, 0, 0, 0, 0, 3));
        // branch after ALU: one stall, then D forward from M
        add("alu_w3_b",       wr(3, 1),   o(0, 0, 0, 0, 0, 0));
        add("br_r3_stall",    br(3, 6),   o(1, 1, 0, 0, 0, 0));
        add("br_r3_fwd",      br(3, 6),   o(0, 0, 2, 0, 0, 0));
        add("br_in_e_fwd",    nop(),      o(0, 0, 0, 0, 3, 0));
        // branch after load: two stalls, then D forward from W
        add("ld_w3",          wr(3, 2),   o(0, 0, 0, 0, 0, 0));
        add("br_ld_stall1",   br(3, 6),   o(1, 1, 0, 0, 0, 0));
        add("br_ld_stall2",   br(3, 6),   o(1, 1, 0, 0, 0, 0));
        add("br_ld_fwd",      br(3, 6),   o(0, 0, 3, 0, 0, 0));
        add("br_ld_retired",  nop(),      o(0, 0, 0, 0, 0, 0));
        // two producers of r7: the younger (M) wins over the older (W)
        add("alu_w7_a",       wr(7, 1),   o(0, 0, 0, 0, 0, 0));
        add("alu_w7_b",       wr(7, 1),   o(0, 0, 0, 0, 0, 0));
        add("rd_r7",          rd(7, 7),   o(0, 0, 0, 0, 0, 0));
        add("youngest_wins",  nop(),      o(0, 0, 0, 0, 2, 2));
        add("idle_2",         nop(),      o(0, 0, 0, 0, 0, 0));
        // load to r0
        add("ld_w0",          wr(0, 2),   o(0, 0, 0, 0, 0, 0));
`ifdef PIPE_HAZARD_SB_R0_ZERO_EN
        add("rd_r0",          rd(0, 9),   o(0, 0, 0, 0, 0, 0));
        add("rd_r0_b",        rd(0, 9),   o(0, 0, 0, 0, 0, 0));
        add("r0_fwd",         nop(),      o(0, 0, 0, 0, 0, 0));
`else
        add("rd_r0",          rd(0, 9),   o(1, 1, 0, 0, 0, 0));
        add("rd_r0_b",        rd(0, 9),   o(0, 0, 0, 0, 0, 0));
        add("r0_fwd",         nop(),      o(0, 0, 0, 0, 3, 0));
`endif
        // reset mid-flight discards the pending load
        add("ld_w5_pre",      wr(5, 2),   o(0, 0, 0, 0, 0, 0));
        add("rst_pulse",      rst_in,     o(0, 0, 0, 0, 0, 0));
        add("rd_r5_after_rst", rd(5, 5),  o(0, 0, 0, 0, 0, 0));
        add("no_fwd_after_rst", nop(),    o(0, 0, 0, 0, 0, 0));

        drive(rst_in);
        repeat (3) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].name, vecs[i].stim, vecs[i].exp);
        end

        // HoldAll freezes state: the load stays in E for all three held cycles,
        // so on release the reader still sees a fresh load-use hazard.
        step("hold_ld",       wr(5, 2),       o(0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            step("hold_frz",  held(rd(5, 2)), o(1, 0, 0, 0, 0, 0));
        end
        step("hold_release",  rd(5, 2),       o(1, 1, 0, 0, 0, 0));
        step("hold_go",       rd(5, 2),       o(0, 0, 0, 0, 0, 0));
        step("hold_fwd_w",    nop(),          o(0, 0, 0, 0, 3, 0));
        step("hold_no_haz",   held(nop()),    o(1, 0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_sb.md
Name: pipe_hazard_sb

Overview:
Parametrised scoreboard hazard unit for the in-order pipelined core. It generalises the fixed 5-stage stall/forward logic to NSTG post-decode stages, with a per-instruction result-ready stage. It tracks destination registers of in-flight instructions in an internal shift pipeline and drives the D-stage stall, the E-stage bubble, and the D- and E-stage operand forward selects. It sits beside the D-stage register, the control unit and the E/M/W pipeline registers.

Parameters:
NREG, 32, architectural register count
AW, 5, register address width (= clog2(NREG))
NSTG, 3, post-decode stages tracked; index 0 = E, 1 = M, ..., NSTG-1 = W
FW, 2, forward-select width (= clog2(NSTG+1))
RW, 2, width of ready-stage field

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
validD  in  1  D-stage instruction valid
rsD  in  AW  D source A address
rtD  in  AW  D source B address
useRsD  in  1  D instruction reads rsD
useRtD  in  1  D instruction reads rtD
BranchD  in  1  D instruction compares operands in D
RFWED  in  1  D instruction writes register file
RFAD  in  AW  D destination address (after rt/rd select)
RdyD  in  RW  first stage index whose output holds the result (ALU = 1, load = 2)
HoldAll  in  1  external freeze of entire pipeline
Stall  out  1  1 = hold PC and D register
FlushE  out  1  1 = load bubble into E register
ForwardAD  out  FW  D operand A source
ForwardBD  out  FW  D operand B source
ForwardAE  out  FW  E operand A source
ForwardBE  out  FW  E operand B source

Behaviour:
- State: entry[k] = {v, wa, rdy} for k = 0..NSTG-1; rsE, rtE, useRsE, useRtE latched from D.
- Forward-select encoding: 0 = register file; k+1 = output of stage k. Stage 0 is never a source, because RdyD >= 1 is required. RdyD = 0 or RdyD > NSTG-1 is illegal.
- Match(r, k): entry[k].v && entry[k].wa == r. The youngest match (lowest k) wins. An older matching entry is ignored.
- E forward: for rsE with youngest match k: select k+1 if k >= entry[k].rdy, otherwise 0. The same rule applies to rtE. With no match, select 0.
- D forward, used only when BranchD: youngest match k with k >= rdy gives k+1, otherwise 0. When BranchD = 0, select 0.
- Hazard for source r (used, validD):
  - E-use: youngest match k with k+1 < rdy.
  - Branch-use (BranchD): youngest match k with k < rdy.
- Stall = HoldAll | hazard on rs | hazard on rt. FlushE = hazard & ~HoldAll.
- Stall, FlushE and the forward selects are combinational from state and D inputs.
- Clock edge, in priority order:
  - rst: all entry.v = 0; rsE = rtE = 0; useRsE = useRtE = 0.
  - HoldAll: all state holds.
  - Otherwise: entry[k] <= entry[k-1] for k >= 1, and entry[NSTG-1] retires. entry[0] <= {validD & RFWED & ~hazard, RFAD, RdyD}. rsE/rtE/use flags <= D values, or 0 when hazard (bubble).
- Reset values: no valid entries, so Stall = FlushE = 0 (unless HoldAll) and all forward selects = 0.
- Reset mid-operation discards all pending producers. The next cycle shows no stall and no forwarding.
- A taken-branch clear of D is applied upstream: the cleared D drives validD = 0 and is recorded as an invalid entry.
- W-stage forward (NSTG) covers the same-cycle register file write. The register file is not required to be write-through.

Optional Feature:
Macro PIPE_HAZARD_SB_R0_ZERO_EN.
- Defined: address 0 never matches, never stalls and never forwards; entries with wa = 0 are stored with v = 0.
- Undefined: register 0 is treated like any other register.

Test Plan:
All scenarios use NSTG = 3.
1. ALU writes r3 (RdyD = 1); next instruction reads rs = 3 -> Stall = 0; next cycle ForwardAE = 2 (M).
2. Load writes r5 (RdyD = 2); next instruction reads rt = 5 -> Stall = 1 and FlushE = 1 for exactly 1 cycle; then ForwardBE = 3 (W).
3. ALU writes r3, followed by a branch reading r3 -> Stall for 1 cycle, then ForwardAD = 2. A load followed by a branch -> Stall for 2 cycles, then ForwardAD = 3.
4. r7 written by instructions in both M and W; E reads r7 -> ForwardAE = 2 (youngest wins).
5. Load writes r0 with the macro defined, next instruction reads r0 -> Stall = 0, forward 0. With the macro undefined -> 1-cycle stall.
6. Pending load r5, rst asserted for 1 cycle, then a reader of r5 -> Stall = 0, forward 0. With HoldAll = 1 -> Stall = 1, FlushE = 0, state frozen across 3 cycles.
